// File: rtl/multiword_add_seq.sv
// Sequential multi-precision adder: one 4-bit ripple-carry adder, one nibble per cycle.
// Optional subtract mode is enabled by defining MWADD_SUB_EN.

module RCA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];
endmodule

module multiword_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MWADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCH = WIDTH / 4;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [NCH-1:0][3:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic [IW-1:0]       idx_q, idx_d;

  logic [WIDTH-1:0]    b_in;
  logic                c_in;
  logic [3:0]          rca_s;
  logic                rca_co;

  RCA_4bit u_rca (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .s    (rca_s),
    .cout (rca_co)
  );

  // Subtraction is a + ~b + 1; the inverted operand is latched so ovf sees it.
  always_comb begin
    b_in = b;
    c_in = cin;
`ifdef MWADD_SUB_EN
    if (sub) begin
      b_in = ~b;
      c_in = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q] = rca_s;
        carry_d      = rca_co;
        idx_d        = idx_q + 1'b1;
        if (idx_q == IW'(NCH - 1)) begin
          cout_d  = rca_co;
          ovf_d   = (a_q[NCH-1][3] == b_q[NCH-1][3]) && (rca_s[3] != a_q[NCH-1][3]);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized + directed bench for multiword_add_seq against a cycle-level arithmetic model.
module tb_multiword_add_seq;
  localparam int W   = 16;
  localparam int NCH = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  multiword_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MWADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: m_cnt = 0 idle, 1..NCH chunks pending, NCH+1 result held.
  int           m_cnt = 0;
  logic [W:0]   m_full = '0;
  logic         m_ovf_full = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] be;
    logic         ce;
    logic [31:0]  mk;
    if (rst) begin
      m_cnt = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_cnt == 0) begin
      if (in_valid) begin
        be = b;
        ce = cin;
`ifdef MWADD_SUB_EN
        if (sub) begin be = ~b; ce = 1'b1; end
`endif
        m_full     = {1'b0, a} + {1'b0, be} + (W+1)'(ce);
        m_ovf_full = (a[W-1] == be[W-1]) && (m_full[W-1] != a[W-1]);
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        m_cnt = 1;
      end
    end else if (m_cnt <= NCH) begin
      mk    = (32'd1 << (4 * m_cnt)) - 32'd1;
      m_sum = m_full[W-1:0] & W'(mk);
      if (m_cnt == NCH) begin
        m_cout = m_full[W];
        m_ovf  = m_ovf_full;
      end
      m_cnt++;
    end else if (out_ready) begin
      m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  {31'd0, in_ready},  {31'd0, (m_cnt == 0)});
      check("out_valid", {31'd0, out_valid}, {31'd0, (m_cnt == NCH + 1)});
      check("sum",       {16'd0, sum},       {16'd0, m_sum});
      check("cout",      {31'd0, cout},      {31'd0, m_cout});
      check("ovf",       {31'd0, ovf},       {31'd0, m_ovf});
    end
  end

  // Called at posedge+2 with the block idle; returns at posedge+2 after one DONE edge.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    input logic ts, input logic [W-1:0] es, input logic ec,
                    input logic eo, input string nm);
    int cyc;
    bit got;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    check({nm, " done_seen"}, {31'd0, got}, 32'd1);
    check({nm, " latency"}, cyc, NCH);
    check({nm, " sum"}, {16'd0, sum}, {16'd0, es});
    check({nm, " cout"}, {31'd0, cout}, {31'd0, ec});
    check({nm, " ovf"}, {31'd0, ovf}, {31'd0, eo});
    @(posedge clk); #2;
  endtask

  initial begin
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst sum", {16'd0, sum}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add1");
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_all");
    op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "cin_all");
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");

    // Back-pressure in DONE with a new request pending.
    out_ready = 1'b0;
    op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, "hold");
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold out_valid", {31'd0, out_valid}, 32'd1);
      check("hold in_ready", {31'd0, in_ready}, 32'd0);
      check("hold sum", {16'd0, sum}, 32'h1010);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check("release idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (NCH) @(posedge clk);
    @(negedge clk);
    check("pending out_valid", {31'd0, out_valid}, 32'd1);
    check("pending sum", {16'd0, sum}, 32'h3333);
    @(posedge clk); #2;

    // Reset during the second RUN cycle.
    a = 16'h0F0F; b = 16'h0F0F; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst sum", {16'd0, sum}, 32'd0);
    @(posedge clk); #2;
    op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst");

`ifdef MWADD_SUB_EN
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    op(16'h0005, 16'h0007, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0, "sub_off");
`endif

    // Random traffic with occasional reset; the compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = ~a;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 59) == 0);
      @(posedge clk); #2;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (NCH + 4) @(posedge clk);
    @(negedge clk);
    check("drain idle", {31'd0, in_ready}, 32'd1);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
